// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer: byte width, default depth
// and the capture FSM state encoding.
package uart_rx_buffer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_SETTLE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_rx_buffer_byte_fifo.sv
// Synchronous show-ahead FIFO with an explicit occupancy counter. A write
// while full is still accepted when a pop happens in the same cycle.
module uart_rx_buffer_byte_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_pop;
    logic                  w_push;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pop first so a full FIFO can take a byte in the slot being freed.
    assign w_pop  = i_rd_en & ~o_empty;
    assign w_push = i_wr_en & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: captures each byte from the UART receiver handshake,
// acknowledges it, and queues it in a FIFO with a sticky overrun flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for data_ready; captures the byte and raises ack
// ST_ACK    | ack is high; receiver sees it at the end of this cycle
// ST_SETTLE | receiver is dropping data_ready; do not resample yet
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [BYTE_W-1:0]     i_rx_data,
    input  logic                  i_rx_data_ready,
    output logic                  o_rx_data_acknowledge,
    output logic [BYTE_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overrun,
    input  logic                  i_overrun_clear
);

    cap_state_e r_state;
    cap_state_e w_state_next;
    logic       r_ack;
    logic       r_overrun;
    logic       w_wr_en;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_rx_data_ready) begin
                    w_wr_en      = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK:    w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // When full the FIFO is non-empty, so a pop is exactly i_rd_ready.
    assign w_drop = w_wr_en & w_full & ~i_rd_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack <= w_wr_en;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_rx_buffer_byte_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (i_rx_data),
        .i_rd_en   (i_rd_ready),
        .o_rd_data (o_rd_data),
        .o_level   (o_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign o_rx_data_acknowledge = r_ack;
    assign o_overrun             = r_overrun;
    assign o_rd_valid            = ~w_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: receiver model, occupancy/flag reference model
// and a byte scoreboard checked whenever the DUT pops.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       ovr;
    logic       ovr_clr;

    uart_rx_buffer #(.DEPTH_LOG2(4)) dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_rx_data             (rx_data),
        .i_rx_data_ready       (rx_rdy),
        .o_rx_data_acknowledge (ack),
        .o_rd_data             (rd_data),
        .o_rd_valid            (rd_valid),
        .i_rd_ready            (rd_ready),
        .o_level               (level),
        .o_overrun             (ovr),
        .i_overrun_clear       (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Receiver: holds data_ready until it has seen ack, then either drops it
    // or immediately presents the next pending byte.
    logic [7:0] txq[$];
    int rx_loaded = 0;
    int rx_acked  = 0;

    initial begin
        logic a;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            if (rx_rdy && a) begin
                rx_acked++;
                rx_rdy = 1'b0;
            end
            if (!rx_rdy && txq.size() > 0) begin
                rx_data = txq.pop_front();
                rx_rdy  = 1'b1;
                rx_loaded++;
            end
        end
    end

    // Reference model: a byte is captured whenever data_ready is seen with
    // no capture in the previous two cycles; it enters the FIFO unless the
    // FIFO is full and nothing is popped in that cycle.
    logic [7:0] exp_q[$];
    int m_level = 0;
    int m_cool  = 0;
    bit m_ovr   = 0;
    bit m_ack   = 0;

    always @(negedge clk) begin
        bit pop, wr, acc, drop;
        if (started) begin
            check("ack", int'(ack), int'(m_ack));
            check("level", int'(level), m_level);
            check("rd_valid", int'(rd_valid), int'(m_level != 0));
            check("overrun", int'(ovr), int'(m_ovr));
            if (reset) begin
                m_level = 0; m_cool = 0; m_ovr = 0; m_ack = 0;
                exp_q.delete();
            end else begin
                pop  = (m_level > 0) && rd_ready;
                wr   = (m_cool == 0) && rx_rdy;
                acc  = wr && ((m_level < DEPTH) || pop);
                drop = wr && !acc;
                if (acc) exp_q.push_back(rx_data);
                m_level = m_level + int'(acc) - int'(pop);
                if (drop) m_ovr = 1;
                else if (ovr_clr) m_ovr = 0;
                m_ack  = wr;
                m_cool = wr ? 2 : (m_cool > 0 ? m_cool - 1 : 0);
            end
        end
    end

    // Scoreboard monitor: compares the head byte on every DUT pop.
    always @(negedge clk) begin
        if (started && !reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("sb_nonempty", exp_q.size(), 1);
            else check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        tick(DEPTH + 4);
        rd_ready = 1'b0;
        tick(1);
        check("drain_level", int'(level), 0);
    endtask

    task automatic fill_17(input logic [7:0] base);
        for (int i = 0; i < 17; i++) txq.push_back(base + 8'(i));
        tick(17 * 3 + 8);
        check("fill_level", int'(level), 16);
        check("fill_overrun", int'(ovr), 1);
    endtask

    initial begin
        bit got_ack;
        reset    = 1'b1;
        rd_ready = 1'b0;
        ovr_clr  = 1'b0;
        tick(3);
        started = 1;
        reset   = 1'b0;
        check("reset_level", int'(level), 0);
        check("reset_valid", int'(rd_valid), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_overrun", int'(ovr), 0);

        // single byte
        txq.push_back(8'h41);
        tick(8);
        check("single_level", int'(level), 1);
        check("single_data", int'(rd_data), 'h41);
        check("single_acks", rx_acked, 1);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        check("single_pop_level", int'(level), 0);
        check("single_pop_valid", int'(rd_valid), 0);

        // back-to-back bytes from the receiver
        txq.push_back(8'hAA);
        txq.push_back(8'h55);
        tick(12);
        check("b2b_level", int'(level), 2);
        check("b2b_head", int'(rd_data), 'hAA);
        check("b2b_acks", rx_acked, 3);
        drain();

        // fill, overrun, clear alone
        fill_17(8'h00);
        check("fill_acks", rx_acked, 20);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("clear_alone", int'(ovr), 0);

        // write while full with a pop in the same cycle
        txq.push_back(8'h99);
        tick(1);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(5);
        check("fullpop_level", int'(level), 16);
        check("fullpop_overrun", int'(ovr), 0);
        drain();

        // clear colliding with a drop
        fill_17(8'h20);
        txq.push_back(8'hEE);
        tick(1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("clear_collision", int'(ovr), 1);
        tick(3);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("clear_after", int'(ovr), 0);
        drain();

        // reset during ACK with level 3, receiver still holding a byte
        for (int i = 0; i < 3; i++) txq.push_back(8'h61 + 8'(i));
        tick(15);
        check("pre_reset_level", int'(level), 3);
        txq.push_back(8'h77);
        txq.push_back(8'h78);
        got_ack = 0;
        for (int i = 0; i < 12 && !got_ack; i++) begin
            tick(1);
            if (ack) begin
                got_ack = 1;
                reset   = 1'b1;
            end
        end
        check("ack_before_reset", int'(got_ack), 1);
        tick(1);
        check("rst_level", int'(level), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_valid", int'(rd_valid), 0);
        tick(1);
        reset = 1'b0;
        tick(8);
        check("post_reset_level", int'(level), 1);
        check("post_reset_data", int'(rd_data), 'h78);
        drain();

        // randomized traffic: congested first, then mostly draining
        for (int c = 0; c < 2500; c++) begin
            tick(1);
            rd_ready = ($urandom_range(99) < (c < 1200 ? 15 : 70));
            if ($urandom_range(99) < 35 && txq.size() < 4) txq.push_back(8'($urandom));
            ovr_clr = ($urandom_range(99) < 3);
            reset   = ($urandom_range(999) < 3);
        end
        reset   = 1'b0;
        ovr_clr = 1'b0;

        // let every pending byte through and empty the FIFO
        rd_ready = 1'b1;
        begin
            int budget = 400;
            while ((txq.size() > 0 || rx_rdy || exp_q.size() > 0 || level != 0) && budget > 0) begin
                tick(1);
                budget--;
            end
            check("final_drain_in_time", int'(budget > 0), 1);
        end
        tick(3);
        rd_ready = 1'b0;
        check("final_level", int'(level), 0);
        check("final_sb_empty", exp_q.size(), 0);
        check("all_bytes_acked", rx_acked, rx_loaded);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
